ram_row_packer: RTL
===================

Name: ram_row_packer

Overview:
- Upstream write stage for the single-clock byte-enable block RAM.
- Accepts a stream of spans (bytes) on a valid/ready handshake and packs them little-endian into rows of NUM_SPANS spans.
- Drives the RAM write port (mask/address/data), one row per write. Row address auto-increments.
- A flush commits a partial row using the byte-enable mask. An address load repositions the write pointer.

Parameters:
- ADDR_NBITS, 5, RAM row-address width (2**ADDR_NBITS rows).
- SPAN_NBITS, 8, bits per span (one byte).
- NUM_SPANS, 8, spans per row; must be ≥2.

Ports:
- clk_in  input  1  single clock, all state on rising edge.
- rstn_in  input  1  reset, asynchronous, active-low.
- inData_in  input  SPAN_NBITS  incoming span.
- inValid_in  input  1  inData_in is valid.
- inReady_out  output  1  span accepted when inValid_in && inReady_out.
- flush_in  input  1  commit the partial row at the end of this cycle.
- addrLoad_in  input  1  load the next row address; discard the partial row.
- addrLoadVal_in  input  ADDR_NBITS  address to load.
- wrMask_out  output  NUM_SPANS  RAM byte-enables; '0 means no write this cycle.
- wrAddr_out  output  ADDR_NBITS  RAM row address.
- wrData_out  output  NUM_SPANS*SPAN_NBITS  RAM row data; span i at bits [i*SPAN_NBITS +: SPAN_NBITS].
- wrapped_out  output  1  sticky: row pointer has wrapped past the top row.

Behaviour:
- Reset (rstn_in low, async): all state cleared.
  - inReady_out=0, wrMask_out='0, wrAddr_out='0, wrData_out='0, wrapped_out=0.
  - Span index=0, accumulated mask='0, row pointer=0. Any partial row is lost.
- inReady_out = readyReg && !addrLoad_in. readyReg is 0 in reset and goes to 1 on the first clock edge after rstn_in deasserts; thereafter it stays 1. This is the only combinational path, addrLoad_in -> inReady_out.
- Accept: the k-th accepted span of a row is written into span k of the accumulator, and accMask bit k is set. Span index increments. Bubbles (inValid_in low) are allowed anywhere and hold state.
- Row complete: an accepted span at index NUM_SPANS-1 causes a registered write on the next cycle.
  - wrMask_out=all-ones, wrData_out=accumulator including that span, wrAddr_out=row pointer.
  - Row pointer increments, span index and accMask clear.
  - Latency is one cycle from the accepting edge to the write, at full throughput: one span per cycle, no stall between rows.
- Flush (flush_in high, addrLoad_in low):
  - If a span is accepted the same cycle, it is included first.
  - If the resulting accMask is non-zero and the row is not already complete, write wrMask_out=accMask next cycle, with unwritten spans of wrData_out = 0. Row pointer increments, span index and accMask clear.
  - Flush with an empty row: no write, pointer unchanged.
  - Flush coinciding with a completing span: exactly one full-mask write.
- Address load (addrLoad_in high):
  - Highest priority. The partial row is discarded without a write and no span is accepted (inReady_out=0); flush_in is ignored.
  - Row pointer=addrLoadVal_in, wrapped_out cleared.
  - A row-complete write scheduled by the previous cycle's acceptance still appears on the outputs this cycle.
- Non-write cycles: wrMask_out='0; wrAddr_out and wrData_out hold their last values.
- Wrap: the pointer increments modulo 2**ADDR_NBITS. Committing a row at address 2**ADDR_NBITS-1 sets wrapped_out (sticky until reset or addrLoad_in). Writes continue at row 0; old data is overwritten.
- Every write is fully registered. At most one write per cycle.

Test Plan:
- Reset, then accept 8 spans 0x01..0x08 back-to-back -> one cycle after the 8th: wrMask_out=0xFF, wrAddr_out=0, wrData_out=0x0807060504030201. The following cycle has wrMask_out=0x00.
- Accept 0xAA,0xBB,0xCC, then flush_in alone -> wrMask_out=0x07, wrData_out=0x0000000000CCBBAA, wrAddr_out=0. Next full row writes at addr 1.
- flush_in with an empty row -> no write. flush_in with the 8th span -> exactly one write, mask 0xFF.
- Stream 33 full rows with random inValid_in bubbles -> addresses 0..31 then 0. wrapped_out rises with the addr-31 write. addrLoad_in (val=5) clears it, and the next row goes to addr 5.
- After 4 spans, assert addrLoad_in (val=10) with inValid_in high -> inReady_out=0 that cycle, no write. The next 8 spans write to addr 10 with mask 0xFF.
- Drop rstn_in after 5 spans, mid-clock -> outputs zero immediately. After release, inReady_out=0 for one cycle, and the first full row writes at addr 0 with no stale spans.

Source files
------------

// File: rtl/ram_row_packer.sv
// Packs a stream of spans little-endian into RAM rows and drives a registered
// byte-enable write port with an auto-incrementing row pointer.
module ram_row_packer #(
    parameter int ADDR_NBITS = 5,
    parameter int SPAN_NBITS = 8,
    parameter int NUM_SPANS  = 8
) (
    input  logic                            clk_in,
    input  logic                            rstn_in,
    input  logic [SPAN_NBITS-1:0]           inData_in,
    input  logic                            inValid_in,
    output logic                            inReady_out,
    input  logic                            flush_in,
    input  logic                            addrLoad_in,
    input  logic [ADDR_NBITS-1:0]           addrLoadVal_in,
    output logic [NUM_SPANS-1:0]            wrMask_out,
    output logic [ADDR_NBITS-1:0]           wrAddr_out,
    output logic [NUM_SPANS*SPAN_NBITS-1:0] wrData_out,
    output logic                            wrapped_out
);

    localparam int IDX_NBITS = (NUM_SPANS > 1) ? $clog2(NUM_SPANS) : 1;
    localparam int ROW_NBITS = NUM_SPANS * SPAN_NBITS;
    localparam logic [IDX_NBITS-1:0] LAST_IDX = IDX_NBITS'(NUM_SPANS - 1);

    logic                  ready_q, ready_d;
    logic [IDX_NBITS-1:0]  idx_q, idx_d;
    logic [NUM_SPANS-1:0]  accMask_q, accMask_d;
    logic [ROW_NBITS-1:0]  accData_q, accData_d;
    logic [ADDR_NBITS-1:0] ptr_q, ptr_d;
    logic                  wrapped_q, wrapped_d;
    logic [NUM_SPANS-1:0]  wrMask_q, wrMask_d;
    logic [ADDR_NBITS-1:0] wrAddr_q, wrAddr_d;
    logic [ROW_NBITS-1:0]  wrData_q, wrData_d;

    logic                  accept;
    logic                  complete;
    logic [NUM_SPANS-1:0]  rowMask;
    logic [ROW_NBITS-1:0]  rowData;

    assign inReady_out = ready_q && !addrLoad_in;
    assign accept      = inValid_in && inReady_out;
    assign complete    = accept && (idx_q == LAST_IDX);

    always_comb begin
        ready_d   = 1'b1;
        idx_d     = idx_q;
        accMask_d = accMask_q;
        accData_d = accData_q;
        ptr_d     = ptr_q;
        wrapped_d = wrapped_q;
        wrMask_d  = '0;
        wrAddr_d  = wrAddr_q;
        wrData_d  = wrData_q;

        // Row as it stands after this cycle's span; flush and completion both commit this view.
        rowMask = accMask_q;
        rowData = accData_q;
        if (accept) begin
            rowMask[idx_q]                            = 1'b1;
            rowData[idx_q*SPAN_NBITS +: SPAN_NBITS]   = inData_in;
        end

        if (addrLoad_in) begin
            idx_d     = '0;
            accMask_d = '0;
            accData_d = '0;
            ptr_d     = addrLoadVal_in;
            wrapped_d = 1'b0;
        end else if (complete || (flush_in && (|rowMask))) begin
            wrMask_d  = rowMask;
            wrAddr_d  = ptr_q;
            wrData_d  = rowData;
            ptr_d     = ptr_q + ADDR_NBITS'(1);
            if (&ptr_q) begin
                wrapped_d = 1'b1;
            end
            idx_d     = '0;
            accMask_d = '0;
            accData_d = '0;
        end else if (accept) begin
            idx_d     = idx_q + IDX_NBITS'(1);
            accMask_d = rowMask;
            accData_d = rowData;
        end
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            ready_q   <= 1'b0;
            idx_q     <= '0;
            accMask_q <= '0;
            accData_q <= '0;
            ptr_q     <= '0;
            wrapped_q <= 1'b0;
            wrMask_q  <= '0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
        end else begin
            ready_q   <= ready_d;
            idx_q     <= idx_d;
            accMask_q <= accMask_d;
            accData_q <= accData_d;
            ptr_q     <= ptr_d;
            wrapped_q <= wrapped_d;
            wrMask_q  <= wrMask_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
        end
    end

    assign wrMask_out  = wrMask_q;
    assign wrAddr_out  = wrAddr_q;
    assign wrData_out  = wrData_q;
    assign wrapped_out = wrapped_q;

endmodule
